hash_bcd_display: RTL and testbench

Parametrised button-driven hash display core: debounces a push button, folds a `student_id` into a running hash on every accepted press (with optional hold-to-repeat), and converts the hash to packed BCD with a sequential double-dabble engine. It sits between the board button/ID switches and the seven-segment driver. It supersedes the fixed 16-bit, 5-digit path with configurable width, digit count, debounce length and auto-repeat.

---
 rtl/hash_bcd_display.sv | 196 +++++++++++++++++++
 tb/tb_hash_bcd_display.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_bcd_display.sv
// hash_bcd_display: debounced push button folds student_id into a running
// hash on each accepted press (optionally auto-repeating while held), and a
// sequential double-dabble engine turns the hash into packed BCD digits.
module hash_bcd_display #(
    parameter int ID_WIDTH        = 16,
    parameter int DIGITS          = 5,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  button_in,
    input  logic [ID_WIDTH-1:0]   student_id,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic [15:0]           press_count
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int REP_W  = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int ITER_W = (ID_WIDTH > 2) ? $clog2(ID_WIDTH) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ID_WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic                sync1_q, sync1_d;
    logic                sync_q, sync_d;
    logic                db_q, db_d;
    logic                db_prev_q, db_prev_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic [ID_WIDTH-1:0] hash_q, hash_d;
    logic [15:0]         press_count_q, press_count_d;
    logic                pending_q, pending_d;
    logic [1:0]          state_q, state_d;
    logic [ID_WIDTH-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                bcd_valid_q, bcd_valid_d;

    logic                press_init;
    logic                rep_fire;
    logic                press;
    logic [BCD_W-1:0]    scratch_adj;

    // Double-dabble correction: every digit of 5 or more gets 3 added so the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] s);
        logic [BCD_W-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Two-flop synchroniser on the raw button, then a stable-run debouncer.
    always_comb begin
        sync1_d   = button_in;
        sync_d    = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        db_cnt_d  = '0;
        if (sync_q != db_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_d     = sync_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Press events: one pulse after db rises, plus periodic repeats while held.
    always_comb begin
        press_init = db_q & ~db_prev_q;
        rep_fire   = (REPEAT_CYCLES > 0) && db_q && (rep_cnt_q == REP_LAST);
        press      = press_init | rep_fire;
        if ((REPEAT_CYCLES == 0) || !db_q || press) begin
            rep_cnt_d = '0;
        end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    // Fold student_id into the hash (h*3 + id, truncated) and count presses.
    always_comb begin
        hash_d        = hash_q;
        press_count_d = press_count_q;
        if (press) begin
            hash_d        = hash_q + {hash_q[ID_WIDTH-2:0], 1'b0} + student_id;
            press_count_d = press_count_q + 16'd1;
        end
    end

    // Converter FSM: snapshot the hash, run ID_WIDTH add-3/shift steps, publish.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        shift_d     = shift_q;
        scratch_d   = scratch_q;
        iter_d      = iter_q;
        bcd_d       = bcd_q;
        bcd_valid_d = bcd_valid_q;
        scratch_adj = add3_all(scratch_q);

        if (press && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (press || pending_q) begin
                    state_d   = ST_LOAD;
                    pending_d = 1'b0;
                end
            end
            ST_LOAD: begin
                shift_d   = hash_q;
                scratch_d = '0;
                iter_d    = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                scratch_d = (scratch_adj << 1) | {{(BCD_W-1){1'b0}}, shift_q[ID_WIDTH-1]};
                shift_d   = shift_q << 1;
                iter_d    = iter_q + 1'b1;
                if (iter_q == ITER_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d       = scratch_q;
                bcd_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state registers; synchronous reset returns everything to idle zero.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync_q        <= 1'b0;
            db_q          <= 1'b0;
            db_prev_q     <= 1'b0;
            db_cnt_q      <= '0;
            rep_cnt_q     <= '0;
            hash_q        <= '0;
            press_count_q <= '0;
            pending_q     <= 1'b0;
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            scratch_q     <= '0;
            iter_q        <= '0;
            bcd_q         <= '0;
            bcd_valid_q   <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync_q        <= sync_d;
            db_q          <= db_d;
            db_prev_q     <= db_prev_d;
            db_cnt_q      <= db_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            hash_q        <= hash_d;
            press_count_q <= press_count_d;
            pending_q     <= pending_d;
            state_q       <= state_d;
            shift_q       <= shift_d;
            scratch_q     <= scratch_d;
            iter_q        <= iter_d;
            bcd_q         <= bcd_d;
            bcd_valid_q   <= bcd_valid_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign bcd_valid   = bcd_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign press_count = press_count_q;

endmodule

// File: tb/tb_hash_bcd_display.sv
// Testbench for hash_bcd_display: three instances (defaults, auto-repeat,
// fast debounce with repeat) checked against an event-level hash/BCD model.
`timescale 1ns/1ps

module tb_hash_bcd_display;

    localparam int IDW  = 16;
    localparam int DIG  = 5;
    localparam int DC   = 16;
    localparam int RPT  = 100;
    localparam int PDC  = 2;
    localparam int PRPT = 3;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        btn_a, btn_r, btn_p;
    logic [15:0] id_a, id_r, id_p;
    logic [19:0] bcd_a, bcd_r, bcd_p;
    logic        valid_a, valid_r, valid_p;
    logic        busy_a, busy_r, busy_p;
    logic [15:0] pc_a, pc_r, pc_p;

    int cyc = 0;
    int checks = 0;
    int fails = 0;

    hash_bcd_display #(.ID_WIDTH(IDW), .DIGITS(DIG), .DEBOUNCE_CYCLES(DC), .REPEAT_CYCLES(0)) u_def (
        .sysclk(sysclk), .reset(reset), .button_in(btn_a), .student_id(id_a),
        .bcd_out(bcd_a), .bcd_valid(valid_a), .busy(busy_a), .press_count(pc_a));

    hash_bcd_display #(.ID_WIDTH(IDW), .DIGITS(DIG), .DEBOUNCE_CYCLES(DC), .REPEAT_CYCLES(RPT)) u_rep (
        .sysclk(sysclk), .reset(reset), .button_in(btn_r), .student_id(id_r),
        .bcd_out(bcd_r), .bcd_valid(valid_r), .busy(busy_r), .press_count(pc_r));

    hash_bcd_display #(.ID_WIDTH(IDW), .DIGITS(DIG), .DEBOUNCE_CYCLES(PDC), .REPEAT_CYCLES(PRPT)) u_pend (
        .sysclk(sysclk), .reset(reset), .button_in(btn_p), .student_id(id_p),
        .bcd_out(bcd_p), .bcd_valid(valid_p), .busy(busy_p), .press_count(pc_p));

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [15:0] id;
        int          hold;
        logic [19:0] exp_bcd;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [15:0] next_hash(input logic [15:0] h, input logic [15:0] id);
        int unsigned t;
        t = 32'(h) * 3 + 32'(id);
        return 16'(t % 65536);
    endfunction

    function automatic logic [15:0] hash_after(input int n, input logic [15:0] id);
        logic [15:0] h;
        h = '0;
        for (int i = 0; i < n; i++) h = next_hash(h, id);
        return h;
    endfunction

    function automatic logic [19:0] to_bcd(input logic [15:0] value);
        logic [19:0] r;
        int unsigned v;
        r = '0;
        v = 32'(value);
        for (int i = 0; i < DIG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge sysclk);
    endtask

    task automatic hold_a(input logic level, input int n);
        btn_a = level;
        repeat (n) @(negedge sysclk);
    endtask

    // Clean press on the default instance, then a long quiet low period.
    task automatic applyStimulus(input logic [15:0] id, input int hold);
        @(negedge sysclk);
        id_a = id;
        hold_a(1'b1, hold);
        hold_a(1'b0, DC + 40);
    endtask

    logic [15:0] mh;
    int          mc;

    initial begin
        int k, h, p0, kr, db_fall, n, seen, load_edge, lim, cnt;
        logic [19:0] prev;
        logic        clean;

        vecs[0] = '{id: 16'd12345, hold: 30, exp_bcd: 20'h49380, exp_count: 16'd2};
        vecs[1] = '{id: 16'd12345, hold: 25, exp_bcd: 20'h29413, exp_count: 16'd3};
        vecs[2] = '{id: 16'd0,     hold: 40, exp_bcd: 20'h22703, exp_count: 16'd4};
        vecs[3] = '{id: 16'd65535, hold: 20, exp_bcd: 20'h02572, exp_count: 16'd5};

        reset = 1'b1;
        btn_a = 1'b0; btn_r = 1'b0; btn_p = 1'b0;
        id_a = '0; id_r = 16'd3; id_p = 16'd1;
        repeat (3) @(negedge sysclk);
        checkOutput("reset bcd_out", 32'(bcd_a), 0);
        checkOutput("reset bcd_valid", 32'(valid_a), 0);
        checkOutput("reset busy", 32'(busy_a), 0);
        checkOutput("reset press_count", 32'(pc_a), 0);
        reset = 1'b0;
        repeat (3) @(negedge sysclk);

        // First press: exact latency through debounce, hash and conversion.
        $display("[TB] debounce latency");
        id_a = 16'd12345;
        btn_a = 1'b1;
        k = cyc + 1;
        h = k + DC + 2;
        wait_until(h - 1);
        checkOutput("count before press edge", 32'(pc_a), 0);
        wait_until(h);
        checkOutput("count at press edge", 32'(pc_a), 1);
        wait_until(h + 1);
        checkOutput("busy after load", 32'(busy_a), 1);
        wait_until(h + IDW + 1);
        checkOutput("busy before done", 32'(busy_a), 1);
        checkOutput("valid before done", 32'(valid_a), 0);
        wait_until(k + DC + 20);
        checkOutput("busy after done", 32'(busy_a), 0);
        checkOutput("valid after done", 32'(valid_a), 1);
        checkOutput("first bcd", 32'(bcd_a), 32'h12345);
        hold_a(1'b1, 10);
        hold_a(1'b0, DC + 40);
        checkOutput("no press on release", 32'(pc_a), 1);

        // Table-driven clean presses continuing the hash sequence.
        $display("[TB] hash sequence table");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].id, vecs[i].hold);
            checkOutput($sformatf("table[%0d] bcd", i), 32'(bcd_a), 32'(vecs[i].exp_bcd));
            checkOutput($sformatf("table[%0d] count", i), 32'(pc_a), 32'(vecs[i].exp_count));
            checkOutput($sformatf("table[%0d] idle", i), 32'(busy_a), 0);
        end
        mh = 16'd2572;
        mc = 5;

        // Short high pulses while released, short low gaps while held.
        $display("[TB] glitch rejection");
        @(negedge sysclk);
        id_a = 16'd7;
        for (int i = 0; i < 4; i++) begin
            hold_a(1'b1, 10);
            hold_a(1'b0, 10);
        end
        hold_a(1'b0, 40);
        checkOutput("glitch pulses count", 32'(pc_a), 32'(mc));
        checkOutput("glitch pulses bcd", 32'(bcd_a), 32'(to_bcd(mh)));
        hold_a(1'b1, 30);
        for (int i = 0; i < 3; i++) begin
            hold_a(1'b0, 5);
            hold_a(1'b1, 10);
        end
        hold_a(1'b0, DC + 60);
        mh = next_hash(mh, 16'd7);
        mc++;
        checkOutput("glitch gaps count", 32'(pc_a), 32'(mc));
        checkOutput("glitch gaps bcd", 32'(bcd_a), 32'(to_bcd(mh)));

        // Randomised bouncy presses and pure glitch bursts against the model.
        $display("[TB] random presses");
        for (int it = 0; it < 20; it++) begin
            @(negedge sysclk);
            id_a = 16'($urandom);
            clean = ($urandom_range(0, 2) != 0);
            if (!clean) begin
                repeat ($urandom_range(1, 4)) begin
                    hold_a(1'b1, $urandom_range(1, DC - 2));
                    id_a = 16'($urandom);
                    hold_a(1'b0, $urandom_range(1, 6));
                end
            end else begin
                repeat ($urandom_range(0, 3)) begin
                    hold_a(1'b1, $urandom_range(1, DC - 2));
                    hold_a(1'b0, $urandom_range(1, 4));
                end
                hold_a(1'b1, $urandom_range(DC + 2, 3 * DC));
                repeat ($urandom_range(0, 3)) begin
                    hold_a(1'b0, $urandom_range(1, DC - 2));
                    hold_a(1'b1, $urandom_range(1, 4));
                end
                mh = next_hash(mh, id_a);
                mc++;
            end
            hold_a(1'b0, DC + 40);
            checkOutput($sformatf("random[%0d] count", it), 32'(pc_a), 32'(mc));
            checkOutput($sformatf("random[%0d] bcd", it), 32'(bcd_a), 32'(to_bcd(mh)));
        end

        // Auto-repeat: press and hold for 400 cycles after acceptance.
        $display("[TB] auto-repeat");
        @(negedge sysclk);
        btn_r = 1'b1;
        k = cyc + 1;
        p0 = k + DC + 2;
        wait_until(p0 + 150);
        checkOutput("repeat mid-hold count", 32'(pc_r), 2);
        wait_until(p0 + 400);
        btn_r = 1'b0;
        kr = cyc + 1;
        db_fall = kr + 1 + DC;
        n = 0;
        while (p0 + RPT * n - 1 < db_fall) n++;
        wait_until(p0 + 650);
        checkOutput("repeat total count", 32'(pc_r), 32'(n));
        checkOutput("repeat five presses", 32'(pc_r), 5);
        checkOutput("repeat bcd", 32'(bcd_r), 32'(to_bcd(hash_after(n, 16'd3))));
        checkOutput("repeat valid", 32'(valid_r), 1);

        // Pending: repeats every 3 cycles overlap the 19-cycle conversion.
        $display("[TB] pending conversions");
        @(negedge sysclk);
        btn_p = 1'b1;
        k = cyc + 1;
        p0 = k + PDC + 2;
        kr = p0 + 61;
        db_fall = kr + 1 + PDC;
        n = 0;
        while (p0 + PRPT * n - 1 < db_fall) n++;
        prev = bcd_p;
        seen = 0;
        while (cyc < p0 + 160) begin
            @(negedge sysclk);
            if (cyc == p0 + 60) btn_p = 1'b0;
            if (bcd_p != prev) begin
                load_edge = cyc - IDW - 1;
                lim = load_edge - 1;
                if (lim < p0) cnt = 0;
                else begin
                    cnt = (lim - p0) / PRPT + 1;
                    if (cnt > n) cnt = n;
                end
                checkOutput($sformatf("pending conversion %0d", seen), 32'(bcd_p),
                            32'(to_bcd(hash_after(cnt, 16'd1))));
                seen++;
                prev = bcd_p;
            end
        end
        checkOutput("pending conversions seen", 32'(seen >= 2), 1);
        checkOutput("pending count", 32'(pc_p), 32'(n));
        checkOutput("pending final bcd", 32'(bcd_p), 32'(to_bcd(hash_after(n, 16'd1))));
        checkOutput("pending final idle", 32'(busy_p), 0);

        // Reset mid-SHIFT aborts the conversion; next press starts from hash 0.
        $display("[TB] reset mid-shift");
        @(negedge sysclk);
        id_a = 16'd500;
        btn_a = 1'b1;
        k = cyc + 1;
        h = k + DC + 2;
        wait_until(h + 5);
        checkOutput("busy before reset", 32'(busy_a), 1);
        btn_a = 1'b0;
        reset = 1'b1;
        @(negedge sysclk);
        checkOutput("reset mid-shift bcd", 32'(bcd_a), 0);
        checkOutput("reset mid-shift valid", 32'(valid_a), 0);
        checkOutput("reset mid-shift busy", 32'(busy_a), 0);
        checkOutput("reset mid-shift count", 32'(pc_a), 0);
        reset = 1'b0;
        repeat (5) @(negedge sysclk);
        applyStimulus(16'd500, 30);
        checkOutput("post-reset bcd", 32'(bcd_a), 32'h00500);
        checkOutput("post-reset count", 32'(pc_a), 1);
        checkOutput("post-reset valid", 32'(valid_a), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
